// File: rtl/canvas_painter.sv
// canvas_painter: owns the COLS x ROWS colour canvas, conditions the raw
// pushbuttons, moves a saturating cursor, paints cells, sweeps the canvas
// clear one cell per cycle and overlays a blinking inverted cursor.
module canvas_painter #(
    parameter int COLS            = 40,
    parameter int ROWS            = 30,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_CYCLES   = 25_000_000,
    parameter int BLINK_CYCLES    = 50_000_000
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             btn_up,
    input  logic                             btn_down,
    input  logic                             btn_left,
    input  logic                             btn_right,
    input  logic                             btn_paint,
    input  logic                             btn_clear,
    input  logic [5:0]                       color_sw,
    output logic [COLS-1:0][ROWS-1:0][5:0]   pixels,
    output logic [5:0]                       cursor_x,
    output logic [4:0]                       cursor_y,
    output logic                             busy
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RP_W = $clog2(REPEAT_CYCLES + 1);
    localparam int BL_W = $clog2(BLINK_CYCLES + 1);

    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RP_W-1:0] RP_MAX = RP_W'(REPEAT_CYCLES);
    localparam logic [RP_W-1:0] RP_ONE = RP_W'(1);
    localparam logic [BL_W-1:0] BL_MAX = BL_W'(BLINK_CYCLES - 1);
    localparam logic [5:0]      X_MAX  = 6'(COLS - 1);
    localparam logic [4:0]      Y_MAX  = 5'(ROWS - 1);

    // Button bit positions inside the conditioning vectors.
    localparam int B_UP    = 0;
    localparam int B_DOWN  = 1;
    localparam int B_LEFT  = 2;
    localparam int B_RIGHT = 3;
    localparam int B_PAINT = 4;
    localparam int B_CLEAR = 5;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    logic [5:0]             raw_s;
    logic [5:0]             sync1_r;
    logic [5:0]             sync2_r;
    logic [5:0]             level_r;
    logic [5:0][DB_W-1:0]   db_cnt_r;
    logic [3:0]             dir_prev_r;
    logic                   clear_prev_r;
    logic [3:0][RP_W-1:0]   rep_cnt_r;
    logic [3:0]             rep_hit_s;
    logic [3:0]             move_s;
    logic                   clear_start_s;
    state_t                 state_r;
    state_t                 state_next_s;
    logic [5:0]             sweep_x_r;
    logic [4:0]             sweep_y_r;
    logic [5:0]             cursor_x_next_s;
    logic [4:0]             cursor_y_next_s;
    logic [COLS-1:0][ROWS-1:0][5:0] canvas_r;
    logic [BL_W-1:0]        blink_cnt_r;
    logic                   blink_r;

    assign raw_s = {btn_clear, btn_paint, btn_right, btn_left, btn_down, btn_up};

    // Two-flop synchronizer for the asynchronous button inputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_r <= 6'b000000;
            sync2_r <= 6'b000000;
        end else begin
            sync1_r <= raw_s;
            sync2_r <= sync1_r;
        end
    end

    // Debouncers: the level flips only after DEBOUNCE_CYCLES of sustained disagreement.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_r  <= 6'b000000;
            db_cnt_r <= '0;
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (sync2_r[i] != level_r[i]) begin
                    if (db_cnt_r[i] == DB_MAX) begin
                        level_r[i]  <= ~level_r[i];
                        db_cnt_r[i] <= '0;
                    end else begin
                        db_cnt_r[i] <= db_cnt_r[i] + 1'b1;
                    end
                end else begin
                    db_cnt_r[i] <= '0;
                end
            end
        end
    end

    // Previous debounced levels for rising-edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dir_prev_r   <= 4'b0000;
            clear_prev_r <= 1'b0;
        end else begin
            dir_prev_r   <= level_r[3:0];
            clear_prev_r <= level_r[B_CLEAR];
        end
    end

    // Auto-repeat counters: count from the initial pulse, fire every REPEAT_CYCLES.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rep_cnt_r <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (!level_r[i]) begin
                    rep_cnt_r[i] <= '0;
                end else if (rep_cnt_r[i] == RP_MAX) begin
                    rep_cnt_r[i] <= RP_ONE;
                end else begin
                    rep_cnt_r[i] <= rep_cnt_r[i] + 1'b1;
                end
            end
        end
    end

    // Move pulses from edges and repeats; dropped entirely while clearing.
    always_comb begin
        rep_hit_s = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            rep_hit_s[i] = level_r[i] && (rep_cnt_r[i] == RP_MAX);
        end
        if (state_r == S_IDLE) begin
            move_s        = (level_r[3:0] & ~dir_prev_r) | rep_hit_s;
            clear_start_s = level_r[B_CLEAR] & ~clear_prev_r;
        end else begin
            move_s        = 4'b0000;
            clear_start_s = 1'b0;
        end
    end

    // Saturating cursor update; opposing pulses on one axis cancel.
    always_comb begin
        cursor_x_next_s = cursor_x;
        cursor_y_next_s = cursor_y;
        if (move_s[B_UP] && !move_s[B_DOWN]) begin
            if (cursor_y != 5'd0) cursor_y_next_s = cursor_y - 5'd1;
            else                  cursor_y_next_s = cursor_y;
        end else if (move_s[B_DOWN] && !move_s[B_UP]) begin
            if (cursor_y != Y_MAX) cursor_y_next_s = cursor_y + 5'd1;
            else                   cursor_y_next_s = cursor_y;
        end else begin
            cursor_y_next_s = cursor_y;
        end
        if (move_s[B_LEFT] && !move_s[B_RIGHT]) begin
            if (cursor_x != 6'd0) cursor_x_next_s = cursor_x - 6'd1;
            else                  cursor_x_next_s = cursor_x;
        end else if (move_s[B_RIGHT] && !move_s[B_LEFT]) begin
            if (cursor_x != X_MAX) cursor_x_next_s = cursor_x + 6'd1;
            else                   cursor_x_next_s = cursor_x;
        end else begin
            cursor_x_next_s = cursor_x;
        end
    end

    // Cursor registers drive the outputs directly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cursor_x <= 6'd0;
            cursor_y <= 5'd0;
        end else begin
            cursor_x <= cursor_x_next_s;
            cursor_y <= cursor_y_next_s;
        end
    end

    // Clear FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_r <= S_IDLE;
        else       state_r <= state_next_s;
    end

    // Clear FSM next state: sweep ends after the last cell is written.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (clear_start_s) state_next_s = S_CLEAR;
                else               state_next_s = S_IDLE;
            end
            S_CLEAR: begin
                if ((sweep_x_r == X_MAX) && (sweep_y_r == Y_MAX)) state_next_s = S_IDLE;
                else                                              state_next_s = S_CLEAR;
            end
            default: state_next_s = S_IDLE;
        endcase
    end

    // Sweep counters: held at 0 in IDLE, row index is the inner loop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sweep_x_r <= 6'd0;
            sweep_y_r <= 5'd0;
        end else if (state_r == S_IDLE) begin
            sweep_x_r <= 6'd0;
            sweep_y_r <= 5'd0;
        end else if (sweep_y_r == Y_MAX) begin
            sweep_y_r <= 5'd0;
            sweep_x_r <= (sweep_x_r == X_MAX) ? 6'd0 : sweep_x_r + 6'd1;
        end else begin
            sweep_y_r <= sweep_y_r + 5'd1;
        end
    end

    // Canvas storage: clear sweep writes zero, otherwise paint at the pre-move cursor.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            canvas_r <= '0;
        end else if (state_r == S_CLEAR) begin
            canvas_r[sweep_x_r][sweep_y_r] <= 6'd0;
        end else if (level_r[B_PAINT]) begin
            canvas_r[cursor_x][cursor_y] <= color_sw;
        end
    end

    // Blink phase generator.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt_r <= '0;
            blink_r     <= 1'b0;
        end else if (blink_cnt_r == BL_MAX) begin
            blink_cnt_r <= '0;
            blink_r     <= ~blink_r;
        end else begin
            blink_cnt_r <= blink_cnt_r + 1'b1;
        end
    end

    // Output overlay: inverted cursor cell during the blink-on phase outside a clear.
    always_comb begin
        pixels = canvas_r;
        if (blink_r && (state_r == S_IDLE)) begin
            pixels[cursor_x][cursor_y] = ~canvas_r[cursor_x][cursor_y];
        end else begin
            pixels[cursor_x][cursor_y] = canvas_r[cursor_x][cursor_y];
        end
    end

    assign busy = (state_r == S_CLEAR);

endmodule
